// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM port arbiter and its helpers.
package ram_pkg;

  localparam int RAM_WIDTH = 64;
  localparam int ADDR_SIZE = 12;

  // Identifies which of the two masters owns a grant or a response.
  typedef logic master_id_t;

  localparam master_id_t MID_M0 = 1'b0;
  localparam master_id_t MID_M1 = 1'b1;

  // One response-pipeline stage: an issued read and the master it belongs to.
  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rsp_entry_t;

  // Converts a master id into a one-hot grant vector {m1, m0}.
  function automatic logic [1:0] id_to_onehot(input master_id_t id);
    logic [1:0] oh;
    if (id == MID_M1) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. The pointer selects the winner only when
// both masters request; it moves to the losing side whenever the caller
// reports that the current grant was actually taken (advance).
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output master_id_t grant_id
);

  master_id_t ptr_r;

  // Pick a winner: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant    = 2'b00;
    grant_id = MID_M0;
    case (req)
      2'b01: begin
        grant    = 2'b01;
        grant_id = MID_M0;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = MID_M1;
      end
      2'b11: begin
        grant    = id_to_onehot(ptr_r);
        grant_id = ptr_r;
      end
      default: begin
        grant    = 2'b00;
        grant_id = MID_M0;
      end
    endcase
  end

  // Priority pointer: after a taken grant, favour the master that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= MID_M0;
    end else if (advance) begin
      ptr_r <= ~grant_id;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a RAM with independent read and write
// ports. Each port is arbitrated round-robin; a read that targets the same
// address as the same-cycle write is held back, and read data is routed to
// the issuing master after the fixed RAM read latency.
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = RAM_WIDTH,
  parameter int RD_LAT = 1
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cmd_valid,
  input  logic              m1_cmd_valid,
  output logic              m0_cmd_ready,
  output logic              m1_cmd_ready,
  input  logic              m0_cmd_we,
  input  logic              m1_cmd_we,
  input  logic [ADDR_W-1:0] m0_cmd_addr,
  input  logic [ADDR_W-1:0] m1_cmd_addr,
  input  logic [DATA_W-1:0] m0_cmd_wdata,
  input  logic [DATA_W-1:0] m1_cmd_wdata,
  output logic              m0_rsp_valid,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_rd_address,
  output logic [ADDR_W-1:0] ram_wr_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0]        rd_req_s;
  logic [1:0]        wr_req_s;
  logic [1:0]        rd_grant_s;
  logic [1:0]        wr_grant_s;
  master_id_t        rd_id_s;
  master_id_t        wr_id_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              hazard_s;
  logic              rd_issue_s;
  logic              wr_issue_s;
  rsp_entry_t        rsp_head_s;
  rsp_entry_t        pipe_r [RD_LAT];

  assign rd_req_s = {m1_cmd_valid & ~m1_cmd_we, m0_cmd_valid & ~m0_cmd_we};
  assign wr_req_s = {m1_cmd_valid &  m1_cmd_we, m0_cmd_valid &  m0_cmd_we};

  rr_arb2 u_rd_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rd_req_s),
    .advance  (rd_issue_s),
    .grant    (rd_grant_s),
    .grant_id (rd_id_s)
  );

  rr_arb2 u_wr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (wr_req_s),
    .advance  (wr_issue_s),
    .grant    (wr_grant_s),
    .grant_id (wr_id_s)
  );

  // Select the winning commands and decide what actually issues. A read
  // colliding with the write address waits so it later sees the new data;
  // nothing issues while reset is held.
  always_comb begin
    rd_addr_s  = {ADDR_W{1'b0}};
    wr_addr_s  = {ADDR_W{1'b0}};
    wr_data_s  = {DATA_W{1'b0}};
    if (rd_id_s == MID_M1) begin
      rd_addr_s = m1_cmd_addr;
    end else begin
      rd_addr_s = m0_cmd_addr;
    end
    if (wr_id_s == MID_M1) begin
      wr_addr_s = m1_cmd_addr;
      wr_data_s = m1_cmd_wdata;
    end else begin
      wr_addr_s = m0_cmd_addr;
      wr_data_s = m0_cmd_wdata;
    end
    hazard_s   = (|rd_grant_s) && (|wr_grant_s) && (rd_addr_s == wr_addr_s);
    rd_issue_s = (|rd_grant_s) && !hazard_s && rst_n;
    wr_issue_s = (|wr_grant_s) && rst_n;
  end

  // Drive the RAM strobes and the per-master handshakes; idle outputs are zero.
  always_comb begin
    ram_read       = 1'b0;
    ram_write      = 1'b0;
    ram_rd_address = {ADDR_W{1'b0}};
    ram_wr_address = {ADDR_W{1'b0}};
    ram_data_in    = {DATA_W{1'b0}};
    if (rd_issue_s) begin
      ram_read       = 1'b1;
      ram_rd_address = rd_addr_s;
    end else begin
      ram_read       = 1'b0;
      ram_rd_address = {ADDR_W{1'b0}};
    end
    if (wr_issue_s) begin
      ram_write      = 1'b1;
      ram_wr_address = wr_addr_s;
      ram_data_in    = wr_data_s;
    end else begin
      ram_write      = 1'b0;
      ram_wr_address = {ADDR_W{1'b0}};
      ram_data_in    = {DATA_W{1'b0}};
    end
    m0_cmd_ready = (rd_issue_s && (rd_id_s == MID_M0)) || (wr_issue_s && (wr_id_s == MID_M0));
    m1_cmd_ready = (rd_issue_s && (rd_id_s == MID_M1)) || (wr_issue_s && (wr_id_s == MID_M1));
  end

  // Response pipeline: tracks issued reads until the RAM data is available.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_r[i] <= '{valid: 1'b0, id: MID_M0};
      end
    end else begin
      pipe_r[0] <= '{valid: rd_issue_s, id: rd_id_s};
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign rsp_head_s = pipe_r[RD_LAT-1];

  // Route returning RAM data to its owner; the other master sees zero.
  always_comb begin
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    m0_rsp_rdata = {DATA_W{1'b0}};
    m1_rsp_rdata = {DATA_W{1'b0}};
    if (rsp_head_s.valid) begin
      if (rsp_head_s.id == MID_M1) begin
        m1_rsp_valid = 1'b1;
        m1_rsp_rdata = ram_rdata;
      end else begin
        m0_rsp_valid = 1'b1;
        m0_rsp_rdata = ram_rdata;
      end
    end else begin
      m0_rsp_valid = 1'b0;
      m1_rsp_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (read latency 1 and 2) share one
// stimulus stream; each has its own simple RAM. A transaction-level model
// (grant rules, memory contents, response due times) predicts every output.
module tb_ram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 64;

  typedef struct {
    int          due;
    bit          id;
    bit [DW-1:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;

  logic          cv [2];
  logic          we [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  logic          rdy  [2][2];
  logic          rv   [2][2];
  logic [DW-1:0] rdt  [2][2];
  logic          rrd  [2];
  logic          rwr  [2];
  logic [AW-1:0] radr [2];
  logic [AW-1:0] wadr [2];
  logic [DW-1:0] din  [2];
  logic [DW-1:0] rdat [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int g_rd, g_wr;

  bit          mptr_rd, mptr_wr;
  bit [DW-1:0] mmem [bit [AW-1:0]];
  rsp_t        rq0 [$];
  rsp_t        rq1 [$];

  bit [DW-1:0] mem0 [4096];
  bit [DW-1:0] mem1 [4096];
  bit [DW-1:0] dl0;
  bit [DW-1:0] dl1 [2];

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(cv[0]), .m1_cmd_valid(cv[1]),
    .m0_cmd_ready(rdy[0][0]), .m1_cmd_ready(rdy[0][1]),
    .m0_cmd_we(we[0]), .m1_cmd_we(we[1]),
    .m0_cmd_addr(ad[0]), .m1_cmd_addr(ad[1]),
    .m0_cmd_wdata(wd[0]), .m1_cmd_wdata(wd[1]),
    .m0_rsp_valid(rv[0][0]), .m1_rsp_valid(rv[0][1]),
    .m0_rsp_rdata(rdt[0][0]), .m1_rsp_rdata(rdt[0][1]),
    .ram_read(rrd[0]), .ram_write(rwr[0]),
    .ram_rd_address(radr[0]), .ram_wr_address(wadr[0]),
    .ram_data_in(din[0]), .ram_rdata(rdat[0])
  );

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(cv[0]), .m1_cmd_valid(cv[1]),
    .m0_cmd_ready(rdy[1][0]), .m1_cmd_ready(rdy[1][1]),
    .m0_cmd_we(we[0]), .m1_cmd_we(we[1]),
    .m0_cmd_addr(ad[0]), .m1_cmd_addr(ad[1]),
    .m0_cmd_wdata(wd[0]), .m1_cmd_wdata(wd[1]),
    .m0_rsp_valid(rv[1][0]), .m1_rsp_valid(rv[1][1]),
    .m0_rsp_rdata(rdt[1][0]), .m1_rsp_rdata(rdt[1][1]),
    .ram_read(rrd[1]), .ram_write(rwr[1]),
    .ram_rd_address(radr[1]), .ram_wr_address(wadr[1]),
    .ram_data_in(din[1]), .ram_rdata(rdat[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (rwr[0]) mem0[wadr[0]] <= din[0];
    dl0 <= mem0[radr[0]];
  end
  assign rdat[0] = dl0;

  // RAM with two cycles of read latency.
  always @(posedge clk) begin
    if (rwr[1]) mem1[wadr[1]] <= din[1];
    dl1[0] <= mem1[radr[1]];
    dl1[1] <= dl1[0];
  end
  assign rdat[1] = dl1[1];

  function automatic bit [DW-1:0] mread(input bit [AW-1:0] a);
    if (mmem.exists(a)) return mmem[a];
    return {DW{1'b0}};
  endfunction

  task automatic chk(input string tag, input int k, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d got=%h want=%h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic get_exp(input int k, output bit v, output bit id, output bit [DW-1:0] d);
    rsp_t e;
    v = 1'b0; id = 1'b0; d = '0;
    if (k == 0) begin
      if (rq0.size() > 0 && rq0[0].due == cyc) begin
        e = rq0.pop_front(); v = 1'b1; id = e.id; d = e.data;
      end
    end else begin
      if (rq1.size() > 0 && rq1[0].due == cyc) begin
        e = rq1.pop_front(); v = 1'b1; id = e.id; d = e.data;
      end
    end
  endtask

  task automatic set_cmd(input int m, input bit v, input bit w, input bit [AW-1:0] a, input bit [DW-1:0] d);
    cv[m] = v; we[m] = w; ad[m] = a; wd[m] = d;
  endtask

  task automatic rand_cmd(input int m);
    if ($urandom_range(0, 3) == 0) set_cmd(m, 1'b0, 1'b0, '0, '0);
    else set_cmd(m, 1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)), {$urandom, $urandom});
  endtask

  task automatic model_reset();
    mptr_rd = 1'b0;
    mptr_wr = 1'b0;
    rq0.delete();
    rq1.delete();
  endtask

  // One clock: predict and check all outputs at the falling edge, then advance the model.
  task automatic tick();
    bit rc [2];
    bit wc [2];
    int rwin, wwin;
    bit v, id;
    bit [DW-1:0] d;
    rsp_t e;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      rc[m] = cv[m] && !we[m];
      wc[m] = cv[m] && we[m];
    end
    rwin = -1; wwin = -1;
    if (rc[0] && rc[1]) rwin = int'(mptr_rd); else if (rc[0]) rwin = 0; else if (rc[1]) rwin = 1;
    if (wc[0] && wc[1]) wwin = int'(mptr_wr); else if (wc[0]) wwin = 0; else if (wc[1]) wwin = 1;
    if (!rst_n) begin rwin = -1; wwin = -1; end
    if (rwin >= 0 && wwin >= 0 && ad[rwin] == ad[wwin]) rwin = -1;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_ready", m), k, 64'(rdy[k][m]), 64'((rwin == m) || (wwin == m)));
      end
      chk("ram_read", k, 64'(rrd[k]), 64'(rwin >= 0));
      chk("ram_write", k, 64'(rwr[k]), 64'(wwin >= 0));
      chk("rd_addr", k, 64'(radr[k]), (rwin >= 0) ? 64'(ad[rwin]) : 64'd0);
      chk("wr_addr", k, 64'(wadr[k]), (wwin >= 0) ? 64'(ad[wwin]) : 64'd0);
      chk("wr_data", k, din[k], (wwin >= 0) ? wd[wwin] : 64'd0);
      get_exp(k, v, id, d);
      chk("m0_rsp_valid", k, 64'(rv[k][0]), 64'(v && !id));
      chk("m1_rsp_valid", k, 64'(rv[k][1]), 64'(v && id));
      chk("m0_rsp_rdata", k, rdt[k][0], (v && !id) ? d : 64'd0);
      chk("m1_rsp_rdata", k, rdt[k][1], (v && id) ? d : 64'd0);
    end
    if (rwin >= 0) begin
      e.id = (rwin == 1); e.data = mread(ad[rwin]);
      e.due = cyc + 1; rq0.push_back(e);
      e.due = cyc + 2; rq1.push_back(e);
      mptr_rd = (rwin == 0);
    end
    if (wwin >= 0) begin
      mmem[ad[wwin]] = wd[wwin];
      mptr_wr = (wwin == 0);
    end
    g_rd = rwin; g_wr = wwin;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    g_rd = -1; g_wr = -1;
    set_cmd(0, 1'b1, 1'b1, 12'h000, 64'h0);
    set_cmd(1, 1'b1, 1'b1, 12'h800, 64'h1);
    // Outputs stay zero while reset is held, even with requests present.
    tick(); tick();
    rst_n = 1'b1;

    // Both masters write continuously: grants alternate m0, m1, ...
    for (int i = 0; i < 10; i++) begin
      tick();
      if (g_wr == 0) set_cmd(0, 1'b1, 1'b1, ad[0] + 12'd1, 64'h1000 + 64'(i));
      if (g_wr == 1) set_cmd(1, 1'b1, 1'b1, ad[1] + 12'd1, 64'h2000 + 64'(i));
    end
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Read/write collision on 0x123: write first, read follows with new data.
    set_cmd(0, 1'b1, 1'b1, 12'h123, 64'hA5A5_A5A5_A5A5_A5A5);
    set_cmd(1, 1'b1, 1'b0, 12'h123, 64'h0);
    tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    tick();
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    // Read and write from different masters in the same cycle.
    set_cmd(0, 1'b1, 1'b0, 12'h010, 64'h0);
    set_cmd(1, 1'b1, 1'b1, 12'hFFF, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    // Back-to-back reads with alternating owners.
    set_cmd(0, 1'b1, 1'b0, 12'h001, 64'h0); tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    set_cmd(1, 1'b1, 1'b0, 12'h002, 64'h0); tick();
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    set_cmd(0, 1'b1, 1'b0, 12'h003, 64'h0); tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    // Reset with a read in flight: its response must never appear.
    set_cmd(0, 1'b1, 1'b0, 12'h005, 64'h0);
    tick();
    rst_n = 1'b0;
    model_reset();
    set_cmd(0, 1'b1, 1'b1, 12'h100, 64'h55);
    set_cmd(1, 1'b1, 1'b1, 12'h101, 64'h66);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    tick();

    // Only m1 reads for five cycles: granted every cycle despite the pointer.
    for (int i = 0; i < 5; i++) begin
      set_cmd(1, 1'b1, 1'b0, 12'h100 + 12'(i % 2), 64'h0);
      tick();
    end
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    // Random traffic on a small address window to provoke ties and collisions.
    rand_cmd(0); rand_cmd(1);
    for (int i = 0; i < 400; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (g_rd == m || g_wr == m || !cv[m]) rand_cmd(m);
      end
    end
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
